// File: rtl/axi_llc_arcane_desc2resp_pkg.sv
// Shared types for the ARCANE LLC response generator: descriptor layout and
// the AXI B/R channel payloads it produces.
package axi_llc_arcane_desc2resp_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_USER_W = 1;
    localparam int unsigned AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]  a_x_id;
        logic [AXI_LEN_W-1:0] a_x_len;
        axi_resp_e            x_resp;
        logic                 rw;
    } desc_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        axi_resp_e             resp;
        logic [AXI_USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        axi_resp_e             resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } r_chan_t;

endpackage

// File: rtl/axi_llc_arcane_desc2resp.sv
// Turns completed LLC descriptors into AXI B responses (Write=1) or streams
// read data as R beats (Write=0), with a zero-bubble bypass on the final beat.
module axi_llc_arcane_desc2resp
    import axi_llc_arcane_desc2resp_pkg::*;
#(
    parameter bit          Write = 1'b1,
    localparam int unsigned RespW = Write ? $bits(b_chan_t) : $bits(r_chan_t)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  desc_t                 desc_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [AXI_DATA_W-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic [RespW-1:0]      resp_o,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  dbg_state_o
);

    // Handshakes: a transfer on any channel happens in a cycle where both its
    // valid and ready are high at the rising clock edge; valid never waits on ready.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e               r_state;
    desc_t                r_desc;
    logic [AXI_LEN_W-1:0] r_beat_cnt;

    logic w_in_resp;
    logic w_last;
    logic w_hs;
    logic w_final;
    logic w_desc_hs;

    assign w_in_resp = (r_state == RESP);
    assign w_last    = (r_beat_cnt == '0);
    assign w_hs      = w_in_resp && resp_ready_i && (Write || data_valid_i);
    assign w_final   = w_hs && (Write || w_last);

    // Ready rises during the final handshake so the next descriptor follows without a bubble.
    assign desc_ready_o = !w_in_resp || w_final;
    assign w_desc_hs    = desc_valid_i && desc_ready_o;

    assign resp_valid_o = w_in_resp && (Write || data_valid_i);
    assign data_ready_o = !Write && w_in_resp && resp_ready_i;
    assign dbg_state_o  = w_in_resp;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_desc     <= '0;
            r_beat_cnt <= '0;
        end else if (w_desc_hs) begin
            r_state    <= RESP;
            r_desc     <= desc_i;
            r_beat_cnt <= desc_i.a_x_len;
        end else if (w_final) begin
            r_state <= IDLE;
        end else if (w_hs && !w_last) begin
            r_beat_cnt <= r_beat_cnt - 1'b1;
        end
    end

    if (Write) begin : g_b
        b_chan_t w_b;
        logic    w_unused_rd;

        always_comb begin
            w_b      = '0;
            w_b.id   = r_desc.a_x_id;
            w_b.resp = r_desc.x_resp;
        end

        assign resp_o      = w_b;
        assign w_unused_rd = ^{data_i, r_desc.rw};
    end else begin : g_r
        r_chan_t w_r;
        logic    w_unused_rw;

        // Read data is forwarded combinationally; only id/resp/last come from the descriptor.
        always_comb begin
            w_r      = '0;
            w_r.id   = r_desc.a_x_id;
            w_r.data = data_i;
            w_r.resp = r_desc.x_resp;
            w_r.last = w_last;
        end

        assign resp_o      = w_r;
        assign w_unused_rw = r_desc.rw;
    end

endmodule

// File: tb/tb_axi_llc_arcane_desc2resp.sv
// Directed bench for both B (Write=1) and R (Write=0) builds of the response
// generator, with expected payload queues checked by per-instance monitors.
module tb_axi_llc_arcane_desc2resp;
    import axi_llc_arcane_desc2resp_pkg::*;

    localparam int BW = $bits(b_chan_t);
    localparam int RW = $bits(r_chan_t);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    desc_t                 wr_desc;
    logic                  wr_desc_valid, wr_desc_ready;
    logic [AXI_DATA_W-1:0] wr_data;
    logic                  wr_data_valid, wr_data_ready;
    logic [BW-1:0]         wr_resp;
    logic                  wr_resp_valid, wr_resp_ready, wr_state;

    desc_t                 rd_desc;
    logic                  rd_desc_valid, rd_desc_ready;
    logic [AXI_DATA_W-1:0] rd_data;
    logic                  rd_data_valid, rd_data_ready;
    logic [RW-1:0]         rd_resp;
    logic                  rd_resp_valid, rd_resp_ready, rd_state;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_hs    = 0;
    logic [BW-1:0] exp_b_q[$];
    logic [RW-1:0] exp_r_q[$];

    axi_llc_arcane_desc2resp #(.Write(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .desc_i(wr_desc), .desc_valid_i(wr_desc_valid), .desc_ready_o(wr_desc_ready),
        .data_i(wr_data), .data_valid_i(wr_data_valid), .data_ready_o(wr_data_ready),
        .resp_o(wr_resp), .resp_valid_o(wr_resp_valid), .resp_ready_i(wr_resp_ready),
        .dbg_state_o(wr_state)
    );

    axi_llc_arcane_desc2resp #(.Write(1'b0)) u_r (
        .clk_i(clk), .rst_ni(rst_n),
        .desc_i(rd_desc), .desc_valid_i(rd_desc_valid), .desc_ready_o(rd_desc_ready),
        .data_i(rd_data), .data_valid_i(rd_data_valid), .data_ready_o(rd_data_ready),
        .resp_o(rd_resp), .resp_valid_o(rd_resp_valid), .resp_ready_i(rd_resp_ready),
        .dbg_state_o(rd_state)
    );

    function automatic desc_t mk_desc(input logic [3:0] id, input logic [7:0] len,
                                      input axi_resp_e resp, input logic rw);
        desc_t d;
        d.a_x_id  = id;
        d.a_x_len = len;
        d.x_resp  = resp;
        d.rw      = rw;
        return d;
    endfunction

    function automatic b_chan_t mk_b(input logic [3:0] id, input axi_resp_e resp);
        b_chan_t b;
        b.id   = id;
        b.resp = resp;
        b.user = '0;
        return b;
    endfunction

    function automatic r_chan_t mk_r(input logic [3:0] id, input logic [31:0] data,
                                     input axi_resp_e resp, input logic last);
        r_chan_t r;
        r.id   = id;
        r.data = data;
        r.resp = resp;
        r.last = last;
        r.user = '0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop one expected payload for every handshake the DUT presents.
    always @(negedge clk) begin
        if (wr_resp_valid && wr_resp_ready) begin
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got %0h expected none", wr_resp);
            end else begin
                check("b_payload", 64'(wr_resp), 64'(exp_b_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rd_resp_valid && rd_resp_ready) begin
            rd_hs++;
            if (exp_r_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_unexpected: got %0h expected none", rd_resp);
            end else begin
                check("r_payload", 64'(rd_resp), 64'(exp_r_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int      k;
        int      hs0;
        r_chan_t rs;
        bit      dv_pat[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit      rr_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        wr_desc = '0; wr_desc_valid = 0; wr_data = '0; wr_data_valid = 0; wr_resp_ready = 0;
        rd_desc = '0; rd_desc_valid = 0; rd_data = '0; rd_data_valid = 0; rd_resp_ready = 0;

        // Reset state
        repeat (3) tick();
        check("rst_b_desc_ready", 64'(wr_desc_ready), 64'd1);
        check("rst_b_resp_valid", 64'(wr_resp_valid), 64'd0);
        check("rst_b_data_ready", 64'(wr_data_ready), 64'd0);
        check("rst_b_resp",       64'(wr_resp),       64'd0);
        check("rst_r_desc_ready", 64'(rd_desc_ready), 64'd1);
        check("rst_r_resp_valid", 64'(rd_resp_valid), 64'd0);
        check("rst_r_data_ready", 64'(rd_data_ready), 64'd0);
        rst_n = 1;
        tick();

        // B single
        wr_desc = mk_desc(4'd3, 8'd0, RESP_OKAY, 1'b1);
        wr_desc_valid = 1; wr_resp_ready = 1;
        exp_b_q.push_back(mk_b(4'd3, RESP_OKAY));
        #1 check("b1_desc_ready", 64'(wr_desc_ready), 64'd1);
        tick();
        wr_desc_valid = 0;
        #1 check("b1_valid_n1", 64'(wr_resp_valid), 64'd1);
        tick();
        check("b1_idle", 64'(wr_state), 64'd0);
        check("b1_valid_off", 64'(wr_resp_valid), 64'd0);

        // B backpressure plus bypass
        wr_resp_ready = 0;
        wr_desc = mk_desc(4'd5, 8'd0, RESP_EXOKAY, 1'b1);
        wr_desc_valid = 1;
        exp_b_q.push_back(mk_b(4'd5, RESP_EXOKAY));
        tick();
        wr_desc = mk_desc(4'd6, 8'd0, RESP_OKAY, 1'b1);
        exp_b_q.push_back(mk_b(4'd6, RESP_OKAY));
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", 64'(wr_resp_valid), 64'd1);
            check("bp_stable", 64'(wr_resp), 64'(mk_b(4'd5, RESP_EXOKAY)));
            check("bp_desc_ready", 64'(wr_desc_ready), 64'd0);
            tick();
        end
        wr_resp_ready = 1;
        #1 check("bypass_desc_ready", 64'(wr_desc_ready), 64'd1);
        tick();
        wr_desc_valid = 0;
        #1 check("bypass_no_bubble", 64'(wr_resp_valid), 64'd1);
        check("bypass_second", 64'(wr_resp), 64'(mk_b(4'd6, RESP_OKAY)));
        tick();
        check("bp_idle", 64'(wr_state), 64'd0);

        // R burst, len 3
        rd_resp_ready = 1;
        rd_desc = mk_desc(4'd2, 8'd3, RESP_OKAY, 1'b0);
        rd_desc_valid = 1;
        tick();
        rd_desc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            rd_data = 32'hA0 + 32'(i);
            rd_data_valid = 1;
            exp_r_q.push_back(mk_r(4'd2, 32'hA0 + 32'(i), RESP_OKAY, i == 3));
            #1;
            rs = r_chan_t'(rd_resp);
            check("burst_data_ready", 64'(rd_data_ready), 64'd1);
            check("burst_last", 64'(rs.last), 64'(i == 3));
            tick();
        end
        rd_data_valid = 0;
        #1 check("burst_idle", 64'(rd_state), 64'd0);

        // R stalls, len 1
        rd_desc = mk_desc(4'd7, 8'd1, RESP_OKAY, 1'b0);
        rd_desc_valid = 1;
        tick();
        rd_desc_valid = 0;
        hs0 = rd_hs;
        k = 0;
        exp_r_q.push_back(mk_r(4'd7, 32'hB0, RESP_OKAY, 1'b0));
        exp_r_q.push_back(mk_r(4'd7, 32'hB1, RESP_OKAY, 1'b1));
        for (int i = 0; i < 5; i++) begin
            rd_data_valid = dv_pat[i];
            rd_resp_ready = rr_pat[i];
            rd_data = 32'hB0 + 32'(k);
            #1;
            check("stall_data_ready", 64'(rd_data_ready), 64'(rr_pat[i]));
            check("stall_resp_valid", 64'(rd_resp_valid), 64'(dv_pat[i]));
            tick();
            if (dv_pat[i] && rr_pat[i]) k++;
        end
        rd_data_valid = 0;
        rd_resp_ready = 1;
        #1;
        check("stall_hs_count", 64'(rd_hs - hs0), 64'd2);
        check("stall_idle", 64'(rd_state), 64'd0);

        // Error pass-through, len 2
        rd_desc = mk_desc(4'd9, 8'd2, RESP_SLVERR, 1'b0);
        rd_desc_valid = 1;
        tick();
        rd_desc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            rd_data = 32'hC0 + 32'(i);
            rd_data_valid = 1;
            exp_r_q.push_back(mk_r(4'd9, 32'hC0 + 32'(i), RESP_SLVERR, i == 2));
            tick();
        end
        rd_data_valid = 0;
        #1 check("err_idle", 64'(rd_state), 64'd0);

        // Reset mid-burst
        rd_desc = mk_desc(4'd4, 8'd3, RESP_OKAY, 1'b0);
        rd_desc_valid = 1;
        tick();
        rd_desc_valid = 0;
        rd_data = 32'hD0;
        rd_data_valid = 1;
        exp_r_q.push_back(mk_r(4'd4, 32'hD0, RESP_OKAY, 1'b0));
        tick();
        rd_data_valid = 0;
        rst_n = 0;
        tick();
        check("mid_rst_valid", 64'(rd_resp_valid), 64'd0);
        check("mid_rst_desc_ready", 64'(rd_desc_ready), 64'd1);
        check("mid_rst_idle", 64'(rd_state), 64'd0);
        rst_n = 1;
        rd_desc = mk_desc(4'd1, 8'd0, RESP_OKAY, 1'b0);
        rd_desc_valid = 1;
        tick();
        rd_desc_valid = 0;
        rd_data = 32'hE0;
        rd_data_valid = 1;
        exp_r_q.push_back(mk_r(4'd1, 32'hE0, RESP_OKAY, 1'b1));
        #1 check("post_rst_valid", 64'(rd_resp_valid), 64'd1);
        tick();
        rd_data_valid = 0;
        #1 check("post_rst_idle", 64'(rd_state), 64'd0);

        tick();
        check("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
        check("r_queue_empty", 64'(exp_r_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
